// File: rtl/button_debouncer_1khz.sv
// Debounces NUM_BTN raw buttons on a 1 kHz strobe; emits level plus press/release/long pulses.
// Latency: 2 sync cycles + DEBOUNCE_SAMPLES ticks + 1 cycle; no backpressure, outputs are free-running.
module button_debouncer_1khz #(
  parameter int NUM_BTN          = 4,
  parameter int DEBOUNCE_SAMPLES = 20,
  parameter int LONG_PRESS_MS    = 1000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick_clk,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic [NUM_BTN-1:0] o_btn_press,
  output logic [NUM_BTN-1:0] o_btn_release,
  output logic [NUM_BTN-1:0] o_btn_long
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_t;

  localparam logic [7:0]  DEB_LIM  = 8'(DEBOUNCE_SAMPLES);
  localparam logic [15:0] HOLD_LIM = 16'(LONG_PRESS_MS);

  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] s_btn_q, s_btn_d;
  logic               tick_prev_q, tick_prev_d;
  logic               tick;

  always_comb begin
    sync1_d     = i_btn;
    s_btn_d     = sync1_q;
    tick_prev_d = i_tick_clk;
  end

  // Edge register resets high so a strobe already high at reset release is not a sample.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q     <= '0;
      s_btn_q     <= '0;
      tick_prev_q <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      s_btn_q     <= s_btn_d;
      tick_prev_q <= tick_prev_d;
    end
  end

  assign tick = i_tick_clk & ~tick_prev_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t      state_q, state_d;
    logic [7:0]  deb_cnt_q, deb_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
    logic [7:0]  deb_inc;
    logic [15:0] hold_inc;

    always_comb begin
      state_d    = state_q;
      deb_cnt_d  = deb_cnt_q;
      hold_cnt_d = hold_cnt_q;
      level_d    = level_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      deb_inc    = deb_cnt_q + 8'd1;
      hold_inc   = hold_cnt_q + 16'd1;

      if (tick) begin
        unique case (state_q)
          ST_IDLE: begin
            if (s_btn_q[g]) begin
              if (deb_inc == DEB_LIM) begin
                state_d    = ST_PRESSED;
                level_d    = 1'b1;
                press_d    = 1'b1;
                deb_cnt_d  = 8'd0;
                hold_cnt_d = 16'd0;
              end else begin
                deb_cnt_d = deb_inc;
              end
            end else begin
              deb_cnt_d = 8'd0;
            end
          end
          ST_PRESSED, ST_LONG_HELD: begin
            if (!s_btn_q[g]) begin
              // A 0 sample never advances hold time, so it always beats a long-press completion.
              if (deb_inc == DEB_LIM) begin
                state_d    = ST_IDLE;
                level_d    = 1'b0;
                release_d  = 1'b1;
                deb_cnt_d  = 8'd0;
                hold_cnt_d = 16'd0;
              end else begin
                deb_cnt_d = deb_inc;
              end
            end else begin
              deb_cnt_d = 8'd0;
              if (state_q == ST_PRESSED) begin
                hold_cnt_d = hold_inc;
                if (hold_inc == HOLD_LIM) begin
                  state_d = ST_LONG_HELD;
                  long_d  = 1'b1;
                end
              end
            end
          end
          default: begin
            state_d    = ST_IDLE;
            level_d    = 1'b0;
            deb_cnt_d  = 8'd0;
            hold_cnt_d = 16'd0;
          end
        endcase
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        state_q    <= ST_IDLE;
        deb_cnt_q  <= 8'd0;
        hold_cnt_q <= 16'd0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        deb_cnt_q  <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
      end
    end

    assign o_btn_level[g]   = level_q;
    assign o_btn_press[g]   = press_q;
    assign o_btn_release[g] = release_q;
    assign o_btn_long[g]    = long_q;
  end

endmodule

// File: doc/button_debouncer_1khz.md
Name: button_debouncer_1khz

Overview:
- Multi-button debouncer and press classifier for the fan-control front panel.
- Sits directly downstream of the 1 kHz clock divider and consumes its 1 kHz square wave as a sampling strobe.
- Runs entirely in the 100 MHz system clock domain.
- Produces clean levels plus single-cycle press, release and long-press pulses for the fan-speed FSM.

Parameters:
- NUM_BTN, 4: number of independent button channels.
- DEBOUNCE_SAMPLES, 20: consecutive 1 kHz samples (ms) a new level must hold before it is accepted; legal range 1..255.
- LONG_PRESS_MS, 1000: ms of continuous accepted press before o_btn_long fires; legal range 1..65535.

Ports:
- i_clk, input, 1: system clock, 100 MHz.
- i_reset, input, 1: synchronous active-high reset.
- i_tick_clk, input, 1: 1 kHz square wave from the clock divider, generated from i_clk.
- i_btn, input, NUM_BTN: raw asynchronous button inputs, active-high.
- o_btn_level, output, NUM_BTN: debounced button level.
- o_btn_press, output, NUM_BTN: 1-cycle pulse on an accepted 0->1 transition.
- o_btn_release, output, NUM_BTN: 1-cycle pulse on an accepted 1->0 transition.
- o_btn_long, output, NUM_BTN: 1-cycle pulse once per press, when the hold time reaches LONG_PRESS_MS.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset, sampled only at posedge i_clk.
- Reset state: all outputs 0, all counters 0, all channel FSMs in IDLE, synchronizer flops 0, tick-edge register r_tick_d = 1.
  - r_tick_d resets to 1 so that a high i_tick_clk at reset release does not produce a spurious sample.
- Input synchronization: each i_btn bit passes through a 2-flop synchronizer. The synchronized value s_btn is used everywhere downstream.
- Sample strobe: tick = i_tick_clk & ~r_tick_d, i.e. the rising edge. It is high for exactly one i_clk cycle per 1 ms period. r_tick_d <= i_tick_clk every cycle.
- Channel state and counters: each channel has an independent FSM, a debounce counter (8 bit) and a hold counter (16 bit). Counters and FSMs advance only in tick cycles; outside tick cycles they hold.
- IDLE (level 0):
  - Tick with s_btn = 1: deb_cnt++. When deb_cnt+1 == DEBOUNCE_SAMPLES, go to PRESSED, set level = 1, clear deb_cnt, clear hold_cnt.
  - Tick with s_btn = 0: deb_cnt <= 0.
- PRESSED (level 1):
  - Tick with s_btn = 1: deb_cnt <= 0 and hold_cnt++. When hold_cnt+1 == LONG_PRESS_MS, go to LONG_HELD.
  - Tick with s_btn = 0: deb_cnt++. When it reaches DEBOUNCE_SAMPLES, go to IDLE, set level = 0, clear hold_cnt.
- LONG_HELD (level 1): same release rule as PRESSED. hold_cnt does not count, so o_btn_long cannot refire.
- Simultaneous hold/release: if a tick both completes LONG_PRESS_MS and counts a 0 sample, the 0 sample wins. deb_cnt++ and no long pulse is issued, because hold_cnt advances only on 1 samples.
- Output timing: o_btn_level, press, release and long are registered and change in the cycle after the deciding tick cycle. Pulses are high for exactly 1 i_clk cycle.
- Latency: a clean press is accepted after 2 synchronizer cycles plus DEBOUNCE_SAMPLES ticks plus 1 cycle.
- DEBOUNCE_SAMPLES = 1: the first differing sample is accepted.
- Glitch rejection: any bounce shorter than DEBOUNCE_SAMPLES consecutive samples never changes the level.
- Channel independence: channels are fully independent. Any combination of simultaneous pulses across channels is legal.
- Stalled tick: if i_tick_clk stops toggling, all state freezes and no pulses are produced.
- Reset mid-operation: asserting i_reset during a press returns every channel to IDLE with level 0 on the next edge. No release pulse is issued.
  - If the button is still held after reset, it must debounce again before a press pulse is issued.

Test Plan:
Bench setup for all scenarios: DEBOUNCE_SAMPLES = 4, LONG_PRESS_MS = 10, NUM_BTN = 2, i_tick_clk toggled every 5 cycles (tick every 10 cycles).
- Clean press: i_btn[0] = 1 held -> o_btn_press[0] is one 1-cycle pulse 1 cycle after the 4th tick that sees s_btn = 1, and o_btn_level[0] = 1 from that cycle. o_btn_press[1] stays 0.
- Bounce rejection: toggle i_btn[0] 1,0,1,0 with each value lasting 2 ticks -> o_btn_level[0] stays 0, no pulses. Then hold 1 for 4 ticks -> exactly one press pulse.
- Long press: hold i_btn[0] = 1 for 20 ticks after acceptance -> exactly one o_btn_long[0] pulse, 1 cycle after the 10th post-acceptance tick. Then release for 4 ticks -> one o_btn_release[0] pulse, level back to 0.
- Short press: accept, hold 5 ticks, release -> press and release pulses, no long pulse. A 3-tick release bounce in the middle of the hold must not toggle the level.
- Reset mid-press: assert i_reset for 1 cycle while level[0] = 1 -> all outputs 0 next cycle, no release pulse. Button still held -> new press pulse after 4 more ticks.
- Reset with tick high: release i_reset while i_tick_clk = 1 -> no sample is taken until the next 0->1 edge of i_tick_clk. Check deb_cnt timing against a reference model.
